// File: rtl/i2s_tx_master.sv
// i2s_tx_master
//   I2S master transmitter. Divides the fabric clock into a bit clock,
//   generates word select and shifts stereo frames out MSB-first in standard
//   I2S format (WS leads each channel's MSB by one bit). Frames are queued in
//   a small FIFO; an empty FIFO at a frame boundary sends zeros and raises a
//   sticky underrun flag. One frame_start_o pulse is emitted per frame.
//
// Ports
//   WB_CLK          fabric clock, all logic on its rising edge
//   WB_RST          synchronous active-high reset
//   enable_i        run (1) / stop (0) the serialiser
//   tx_left_i       left sample pushed into the FIFO
//   tx_right_i      right sample pushed into the FIFO
//   tx_push_i       push {left,right}; dropped when tx_full_o=1
//   tx_full_o       FIFO holds FIFO_DEPTH frames
//   tx_level_o      number of frames queued
//   bitclk_o        I2S bit clock (period 2*CLK_DIV clocks)
//   ws_o            word select, 0 = left, 1 = right
//   sdata_o         serial data, changes on bit clock falls
//   frame_start_o   one-cycle pulse when the left MSB of a frame is driven
//   underrun_o      sticky: a frame boundary found the FIFO empty
//   underrun_clr_i  clears underrun_o (a simultaneous underrun wins)
module i2s_tx_master #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              WB_CLK,
  input  logic                              WB_RST,
  input  logic                              enable_i,
  input  logic [DATA_WIDTH-1:0]             tx_left_i,
  input  logic [DATA_WIDTH-1:0]             tx_right_i,
  input  logic                              tx_push_i,
  output logic                              tx_full_o,
  output logic [$clog2(FIFO_DEPTH):0]       tx_level_o,
  output logic                              bitclk_o,
  output logic                              ws_o,
  output logic                              sdata_o,
  output logic                              frame_start_o,
  output logic                              underrun_o,
  input  logic                              underrun_clr_i
);

  localparam int FW  = 2 * DATA_WIDTH;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BCW = $clog2(FW);

  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic           bitclk_q, bitclk_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           ws_q, ws_d;
  logic           sdata_q, sdata_d;
  logic           frame_start_q, frame_start_d;
  logic           underrun_q, underrun_d;
  logic [FW-1:0]  shreg_q, shreg_d;
  logic [LW-1:0]  level_q, level_d;
  logic           full_q, full_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]  fifo_mem_q [FIFO_DEPTH];

  logic           load;
  logic           pop;
  logic           push_ok;
  logic [FW-1:0]  head;

  assign head    = fifo_mem_q[rd_ptr_q];
  assign push_ok = tx_push_i & ~full_q;

  always_comb begin
    div_cnt_d     = div_cnt_q;
    bitclk_d      = bitclk_q;
    bit_cnt_d     = bit_cnt_q;
    ws_d          = ws_q;
    sdata_d       = sdata_q;
    shreg_d       = shreg_q;
    frame_start_d = 1'b0;
    load          = 1'b0;
    pop           = 1'b0;

    if (!enable_i) begin
      // Stopped: park everything so a re-enable starts at a fresh frame.
      div_cnt_d = '0;
      bitclk_d  = 1'b0;
      bit_cnt_d = BCW'(FW - 1);
      ws_d      = 1'b0;
      sdata_d   = 1'b0;
    end else if (div_cnt_q == DCW'(CLK_DIV - 1)) begin
      div_cnt_d = '0;
      bitclk_d  = ~bitclk_q;
      // Falling bit clock edge: advance to the next frame bit.
      if (bitclk_q) begin
        bit_cnt_d = (bit_cnt_q == BCW'(FW - 1)) ? '0 : bit_cnt_q + BCW'(1);
        ws_d      = (bit_cnt_d >= BCW'(DATA_WIDTH - 1)) &&
                    (bit_cnt_d <= BCW'(FW - 2));
        if (bit_cnt_d == '0) begin
          load          = 1'b1;
          frame_start_d = 1'b1;
          if (level_q != '0) begin
            pop     = 1'b1;
            sdata_d = head[FW-1];
            shreg_d = {head[FW-2:0], 1'b0};
          end else begin
            sdata_d = 1'b0;
            shreg_d = '0;
          end
        end else begin
          sdata_d = shreg_q[FW-1];
          shreg_d = {shreg_q[FW-2:0], 1'b0};
        end
      end
    end else begin
      div_cnt_d = div_cnt_q + DCW'(1);
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (load && !pop) begin
      underrun_d = 1'b1;
    end else if (underrun_clr_i) begin
      underrun_d = 1'b0;
    end

    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);

    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == LW'(FIFO_DEPTH));
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      div_cnt_q     <= '0;
      bitclk_q      <= 1'b0;
      bit_cnt_q     <= BCW'(FW - 1);
      ws_q          <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      level_q       <= '0;
      full_q        <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bitclk_q      <= bitclk_d;
      bit_cnt_q     <= bit_cnt_d;
      ws_q          <= ws_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      level_q       <= level_d;
      full_q        <= full_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Data storage is not reset: it is always written before it is read.
  always_ff @(posedge WB_CLK) begin
    shreg_q <= shreg_d;
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= {tx_left_i, tx_right_i};
    end
  end

  assign bitclk_o      = bitclk_q;
  assign ws_o          = ws_q;
  assign sdata_o       = sdata_q;
  assign frame_start_o = frame_start_q;
  assign underrun_o    = underrun_q;
  assign tx_level_o    = level_q;
  assign tx_full_o     = full_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
module tb_i2s_tx_master;
  localparam int DW    = 16;
  localparam int CD    = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, push, clr;
  logic [DW-1:0] tx_l, tx_r;
  logic          full, bclk, ws, sdata, fs, ur;
  logic [LW-1:0] level;

  i2s_tx_master #(.DATA_WIDTH(DW), .CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .WB_CLK        (clk),
    .WB_RST        (rst),
    .enable_i      (en),
    .tx_left_i     (tx_l),
    .tx_right_i    (tx_r),
    .tx_push_i     (push),
    .tx_full_o     (full),
    .tx_level_o    (level),
    .bitclk_o      (bclk),
    .ws_o          (ws),
    .sdata_o       (sdata),
    .frame_start_o (fs),
    .underrun_o    (ur),
    .underrun_clr_i(clr)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: frames in a queue, time measured in enabled cycles.
  logic [2*DW-1:0] mq[$];
  logic [2*DW-1:0] m_cur;
  int              m_t;
  bit              m_ur, m_fs, m_bclk, m_ws, m_sd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit full_pre, load, set_ur;
    int f, b;
    m_fs   = 0;
    load   = 0;
    set_ur = 0;
    if (rst) begin
      mq.delete();
      m_t = 0; m_ur = 0; m_bclk = 0; m_ws = 0; m_sd = 0;
      return;
    end
    full_pre = (mq.size() == DEPTH);
    if (!en) begin
      m_t = 0; m_bclk = 0; m_ws = 0; m_sd = 0;
    end else begin
      m_t++;
      m_bclk = ((m_t / CD) % 2) == 1;
      f = m_t / (2 * CD);
      if (f == 0) begin
        m_ws = 0; m_sd = 0;
      end else begin
        b = (f - 1) % (2 * DW);
        load = ((m_t % (2 * CD)) == 0) && (b == 0);
        if (load) begin
          m_fs = 1;
          if (mq.size() > 0) m_cur = mq.pop_front();
          else begin
            m_cur  = '0;
            set_ur = 1;
          end
        end
        m_ws = (b >= DW - 1) && (b <= 2 * DW - 2);
        m_sd = m_cur[2*DW-1-b];
      end
    end
    if (push && !full_pre) mq.push_back({tx_l, tx_r});
    if (set_ur) m_ur = 1;
    else if (clr) m_ur = 0;
  endtask

  task automatic check_outputs();
    chk("bitclk", bclk, m_bclk);
    chk("ws", ws, m_ws);
    chk("sdata", sdata, m_sd);
    chk("frame_start", fs, m_fs);
    chk("underrun", ur, m_ur);
    chk("level", level, mq.size());
    chk("full", full, mq.size() == DEPTH);
  endtask

  task automatic cyc(input bit r_, input bit e_, input bit p_, input bit c_,
                     input logic [DW-1:0] ll, input logic [DW-1:0] rr);
    rst = r_; en = e_; push = p_; clr = c_; tx_l = ll; tx_r = rr;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    logic [2*DW-1:0] golden;
    bit en_r;
    rst = 1; en = 0; push = 0; clr = 0; tx_l = '0; tx_r = '0;

    // Reset with pushes and enable active.
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, DW'($urandom), DW'($urandom));
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_bitclk", bclk, 0);

    // Basic frame followed by underrun and clear handling.
    golden = 32'hA5F0_0F5A;
    cyc(0, 0, 1, 0, 16'hA5F0, 16'h0F5A);
    chk("basic_level", level, 1);
    for (int t = 1; t <= 260; t++) begin
      cyc(0, 1, 0, (t == 200) || (t == 260), '0, '0);
      if (t == 2) chk("basic_rise", bclk, 1);
      if (t == 4) chk("basic_fall", bclk, 0);
      if (t >= 5 && t <= 129 && (t % 4) == 1)
        chk("basic_bit", sdata, golden[31-(t-5)/4]);
      if (t == 140) chk("ur_set", ur, 1);
      if (t == 200) chk("ur_clr", ur, 0);
      if (t == 260) chk("ur_set_wins", ur, 1);
    end
    cyc(0, 0, 0, 1, '0, '0);

    // Fill beyond depth while stopped, then drain in order.
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, DW'($urandom), DW'($urandom));
    chk("full_level", level, 4);
    chk("full_flag", full, 1);
    for (int t = 1; t <= 5 * 128 + 8; t++) cyc(0, 1, 0, 0, '0, '0);
    chk("drain_ur", ur, 1);

    // Disable mid-frame at bit 10, then restart.
    cyc(0, 0, 0, 1, '0, '0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, DW'($urandom), DW'($urandom));
    for (int t = 1; t <= 46; t++) cyc(0, 1, 0, 0, '0, '0);
    cyc(0, 0, 0, 0, '0, '0);
    chk("dis_bitclk", bclk, 0);
    chk("dis_ws", ws, 0);
    chk("dis_sdata", sdata, 0);
    chk("dis_level", level, 1);
    for (int t = 1; t <= 140; t++) cyc(0, 1, 0, 0, '0, '0);

    // Push while full coinciding with a pop.
    cyc(0, 0, 0, 1, '0, '0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, DW'($urandom), DW'($urandom));
    for (int t = 1; t <= 4; t++) cyc(0, 1, 1, 0, DW'($urandom), DW'($urandom));
    chk("popfull_level", level, 3);
    chk("popfull_full", full, 0);
    for (int t = 0; t < 300; t++) cyc(0, 1, 0, 0, '0, '0);

    // Randomised run.
    en_r = 1;
    for (int i = 0; i < 4000; i++) begin
      if (en_r) en_r = ($urandom % 300) != 0;
      else      en_r = ($urandom % 20) == 0;
      cyc(($urandom % 2000) == 0, en_r, ($urandom % 50) == 0,
          ($urandom % 150) == 0, DW'($urandom), DW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
